// File: rtl/tsq_pkg.sv
// Shared definitions for the transposer sequencer: default tile geometry,
// FSM state and drain-mode encodings, and the perf counter width.
package tsq_pkg;

  localparam int unsigned DefaultDim   = 16;
  localparam int unsigned DefaultElemW = 8;
  localparam int unsigned DefaultRw    = DefaultDim * DefaultElemW;

  localparam int unsigned PerfW = 32;

  // Sequencer states, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StFill  = 2'd1;
  localparam state_t StDrain = 2'd2;

  // Drain mode: FLUSH pushes zero rows, STREAM pushes the next tile's rows.
  typedef logic mode_t;
  localparam mode_t ModeFlush  = 1'b0;
  localparam mode_t ModeStream = 1'b1;

endpackage

// File: rtl/tsq_perf_cnt.sv
// Saturating event counter used for the optional performance statistics.
module tsq_perf_cnt
  import tsq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PerfW-1:0] count
);

  logic [PerfW-1:0] count_q;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {PerfW{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/transposer_sequencer.sv
// Sequences rows into an external DIM x DIM transposer and streams the
// resulting columns downstream. A tile is filled, then drained either by
// flushing (zero rows pushed) or by streaming the next tile's rows in while
// the current columns come out, giving back-to-back tiles without bubbles.
// Optional perf counters are built when TRANSPOSER_SEQ_PERF_EN is defined.
module transposer_sequencer
  import tsq_pkg::*;
#(
  parameter int unsigned DIM    = DefaultDim,
  parameter int unsigned ELEM_W = DefaultElemW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIM*ELEM_W-1:0] in_row,
  output logic                  tp_in_valid,
  output logic [DIM*ELEM_W-1:0] tp_in_row,
  input  logic [DIM*ELEM_W-1:0] tp_out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIM*ELEM_W-1:0] out_col,
  output logic                  out_last,
  output logic                  busy
`ifdef TRANSPOSER_SEQ_PERF_EN
  ,
  output logic [PerfW-1:0]      perf_tiles,
  output logic [PerfW-1:0]      perf_stalls
`endif
);

  localparam int unsigned CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIM - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  mode_t         mode_q, mode_d;

  logic drain_first;
  logic stream_now;
  logic accept;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? '0 : v + 1'b1;
  endfunction

  // Handshake and transposer-push decode for the current state.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    tp_in_valid = 1'b0;
    tp_in_row   = '0;
    stream_now  = 1'b0;
    drain_first = (state_q == StDrain) && (drain_cnt_q == '0);
    case (state_q)
      StIdle, StFill: begin
        in_ready    = 1'b1;
        tp_in_valid = in_valid;
        tp_in_row   = in_row;
      end
      StDrain: begin
        // The first column of a tile picks the mode from in_valid; later ones use the latch.
        stream_now  = drain_first ? in_valid : (mode_q == ModeStream);
        out_valid   = (drain_first || (mode_q == ModeFlush)) ? 1'b1 : in_valid;
        in_ready    = (drain_first || (mode_q == ModeStream)) ? out_ready : 1'b0;
        tp_in_valid = out_valid && out_ready;
        tp_in_row   = stream_now ? in_row : '0;
      end
      default: ;
    endcase
    if (rst) begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      tp_in_valid = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state, counter and mode update.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mode_d      = mode_q;
    case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          fill_cnt_d = wrap_inc(fill_cnt_q);
          state_d    = (fill_cnt_q == CntMax) ? StDrain : StFill;
        end
      end
      StDrain: begin
        if (tp_in_valid) begin
          drain_cnt_d = wrap_inc(drain_cnt_q);
          if (stream_now) begin
            fill_cnt_d = wrap_inc(fill_cnt_q);
          end
          if (drain_first) begin
            mode_d = stream_now ? ModeStream : ModeFlush;
          end
          if (drain_cnt_q == CntMax) begin
            // A streamed drain has fully loaded the next tile, so drain it at once.
            state_d = stream_now ? StDrain : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any partial tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mode_q      <= ModeFlush;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign out_col  = tp_out_col;
  assign out_last = (state_q == StDrain) && (drain_cnt_q == CntMax);
  assign busy     = (state_q != StIdle);

`ifdef TRANSPOSER_SEQ_PERF_EN
  tsq_perf_cnt u_perf_tiles (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && out_ready && out_last),
    .count (perf_tiles)
  );

  tsq_perf_cnt u_perf_stalls (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_transposer_sequencer.sv
// Bench for transposer_sequencer: a behavioural transposer feeds tp_out_col,
// accepted rows build expected columns in a queue, and every column handshake
// pops and compares. Perf counters are checked when TRANSPOSER_SEQ_PERF_EN is set.
module tb_transposer_sequencer;

  localparam int DIM = 16;
  localparam int EW  = 8;
  localparam int RW  = DIM * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic          tp_in_valid;
  logic [RW-1:0] tp_in_row;
  logic [RW-1:0] tp_out_col;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_col;
  logic          out_last;
  logic          busy;
`ifdef TRANSPOSER_SEQ_PERF_EN
  logic [31:0]   perf_tiles;
  logic [31:0]   perf_stalls;
`endif

  transposer_sequencer #(
    .DIM    (DIM),
    .ELEM_W (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .tp_in_valid (tp_in_valid),
    .tp_in_row   (tp_in_row),
    .tp_out_col  (tp_out_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_last    (out_last),
    .busy        (busy)
`ifdef TRANSPOSER_SEQ_PERF_EN
    ,
    .perf_tiles  (perf_tiles),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural transposer: column k of the last full tile appears on push k.
  logic [RW-1:0] fill_buf [DIM];
  logic [RW-1:0] out_buf  [DIM];
  int            tp_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_cnt <= 0;
    end else if (tp_in_valid) begin
      fill_buf[tp_cnt] <= tp_in_row;
      if (tp_cnt == DIM - 1) begin
        for (int r = 0; r < DIM - 1; r++) out_buf[r] <= fill_buf[r];
        out_buf[DIM-1] <= tp_in_row;
        tp_cnt <= 0;
      end else begin
        tp_cnt <= tp_cnt + 1;
      end
    end
  end

  always_comb begin
    tp_out_col = '0;
    for (int j = 0; j < DIM; j++) tp_out_col[j*EW +: EW] = out_buf[j][tp_cnt*EW +: EW];
  end

  typedef struct packed {
    logic          last;
    logic [RW-1:0] col;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] acc_rows [DIM];
  int            acc_idx;
  int            n_checks, n_pass;
  int            n_out, n_acc, n_active, n_stall, stall_bad, flush_bad;
  logic          prev_stall;
  logic [RW-1:0] prev_col;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] row_of(input int base, input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < DIM; j++) r[j*EW +: EW] = 8'(base + DIM * i + j);
    return r;
  endfunction

  // Scoreboard monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_rows[acc_idx] = in_row;
        acc_idx++;
        n_acc++;
        if (acc_idx == DIM) begin
          for (int k = 0; k < DIM; k++) begin
            exp_t e;
            e.last = (k == DIM - 1);
            for (int j = 0; j < DIM; j++) e.col[j*EW +: EW] = acc_rows[j][k*EW +: EW];
            exp_q.push_back(e);
          end
          acc_idx = 0;
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_col", out_col, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("col", out_col, e.col);
          check("last", {127'd0, out_last}, {127'd0, e.last});
        end
        if (!(in_valid && in_ready) && (tp_in_row != '0)) flush_bad++;
      end
      if (prev_stall && (!out_valid || (out_col != prev_col))) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_col   = out_col;
      if (prev_stall) n_stall++;
      if (busy || (in_valid && in_ready)) n_active++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [RW-1:0] row);
    int t;
    logic ok;
    in_valid = 1'b1;
    in_row   = row;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      t++;
    end
    if (!ok) check("push_timeout", '0, 1);
    in_valid = 1'b0;
  endtask

  task automatic push_tile(input int base);
    for (int i = 0; i < DIM; i++) push_row(row_of(base, i));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin
      step();
      t++;
    end
    check("idle_timeout", {127'd0, busy}, '0);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (n_out < n && t < 200) begin
      step();
      t++;
    end
    check("wait_out", n_out, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {127'd0, in_ready}, '0);
    check({tag, "_out_valid"}, {127'd0, out_valid}, '0);
    check({tag, "_tp_in_valid"}, {127'd0, tp_in_valid}, '0);
    check({tag, "_busy"}, {127'd0, busy}, '0);
  endtask

  task automatic clear_stats();
    n_out = 0; n_acc = 0; n_active = 0; n_stall = 0; stall_bad = 0; flush_bad = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] exp_c;
    int            ir_bad, acc0, t;
`ifdef TRANSPOSER_SEQ_PERF_EN
    logic [31:0]   stalls0, tiles0;
`endif
    n_checks = 0; n_pass = 0; acc_idx = 0; prev_stall = 1'b0; prev_col = '0;
    clear_stats();
    rst = 1'b1; in_valid = 1'b1; in_row = '1; out_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");
`ifdef TRANSPOSER_SEQ_PERF_EN
    check("rst_perf_tiles", perf_tiles, '0);
    check("rst_perf_stalls", perf_stalls, '0);
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {127'd0, in_ready}, 1);

    // Single tile, flushed.
    clear_stats();
    push_tile(0);
    check("t1_busy", {127'd0, busy}, 1);
    check("t1_out_valid", {127'd0, out_valid}, 1);
    for (int j = 0; j < DIM; j++) exp_c[j*EW +: EW] = 8'(16 * j);
    check("t1_col0", out_col, exp_c);
    wait_idle();
    check("t1_n_out", n_out, DIM);
    check("t1_active_cycles", n_active, 2 * DIM);
    check("t1_flush_zero_rows", flush_bad, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Three back-to-back tiles streamed.
    clear_stats();
    for (int tl = 0; tl < 3; tl++) push_tile(tl * 7 + 1);
    wait_idle();
    check("t2_n_acc", n_acc, 3 * DIM);
    check("t2_n_out", n_out, 3 * DIM);
    check("t2_active_cycles", n_active, 4 * DIM);
    check("t2_flush_zero_rows", flush_bad, 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Random backpressure during a flush drain.
    clear_stats();
`ifdef TRANSPOSER_SEQ_PERF_EN
    stalls0 = perf_stalls;
    tiles0  = perf_tiles;
`endif
    push_tile(8'h55);
    out_ready = 1'b0;
    step();
    step();
    t = 0;
    while (busy && t < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    out_ready = 1'b1;
    wait_idle();
    check("t3_n_out", n_out, DIM);
    check("t3_stall_stable", stall_bad, 0);
    check("t3_sb_empty", exp_q.size(), 0);
`ifdef TRANSPOSER_SEQ_PERF_EN
    check("t3_perf_stalls", perf_stalls - stalls0, n_stall);
    check("t3_perf_tiles", perf_tiles - tiles0, 1);
`endif

    // Late in_valid during a flush must not switch mode.
    clear_stats();
    push_tile(8'h90);
    wait_out(3);
    in_valid = 1'b1;
    in_row   = row_of(8'h33, 0);
    ir_bad   = 0;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      if (in_ready) ir_bad++;
      step();
      t++;
    end
    check("t4_in_ready_low", ir_bad, 0);
    check("t4_in_ready_idle", {127'd0, in_ready}, 1);
    acc0 = n_acc;
    push_row(row_of(8'h33, 0));
    check("t4_row_accepted", n_acc, acc0 + 1);
    for (int i = 1; i < DIM; i++) push_row(row_of(8'h33, i));
    wait_idle();
    check("t4_n_out", n_out, 2 * DIM);
    check("t4_flush_zero_rows", flush_bad, 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset mid-fill, then mid-drain.
    clear_stats();
    for (int i = 0; i < 9; i++) push_row(row_of(8'h11, i));
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fill");
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    push_tile(8'hA0);
    wait_idle();
    check("t5a_n_out", n_out, DIM);
    check("t5a_sb_empty", exp_q.size(), 0);
    clear_stats();
    push_tile(8'hB0);
    wait_out(7);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_drain");
`ifdef TRANSPOSER_SEQ_PERF_EN
    check("rst_drain_perf_tiles", perf_tiles, '0);
`endif
    step();
    rst = 1'b0;
    clear_stats();
    push_tile(8'hC3);
    wait_idle();
    check("t5b_n_out", n_out, DIM);
    check("t5b_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
